uart_alu_if: RTL

UART_ALU_IF -- requirements
Module: uart_alu_if

---
 rtl/uart_alu_if.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/uart_alu_if.sv
// uart_alu_if: receives a 3-byte frame (A, B, opcode) from a UART RX FIFO,
// computes an ALU result, shows it on leds and pushes it to the UART TX FIFO.
// Ports:
//   CLK, RESET           clock, synchronous active-high reset
//   rx_empty, r_data     RX FIFO status / head byte
//   rd_uart              RX FIFO pop strobe (combinational)
//   tx_full              TX FIFO full flag
//   wr_uart, w_data      TX FIFO push strobe (combinational) / result byte
//   leds                 last computed result
//   busy                 high whenever a frame is in progress
//   timeout_err          one-cycle pulse when a partial frame is abandoned
module uart_alu_if #(
    parameter int unsigned N_BIT   = 8,
    parameter int unsigned TIMEOUT = 1_000_000
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             rx_empty,
    input  logic [N_BIT-1:0] r_data,
    output logic             rd_uart,
    input  logic             tx_full,
    output logic             wr_uart,
    output logic [N_BIT-1:0] w_data,
    output logic [N_BIT-1:0] leds,
    output logic             busy,
    output logic             timeout_err
);

    localparam int unsigned      CNT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [N_BIT-1:0] OP_ADD = N_BIT'(8'h20);
    localparam logic [N_BIT-1:0] OP_SUB = N_BIT'(8'h22);
    localparam logic [N_BIT-1:0] OP_AND = N_BIT'(8'h24);
    localparam logic [N_BIT-1:0] OP_OR  = N_BIT'(8'h25);
    localparam logic [N_BIT-1:0] OP_XOR = N_BIT'(8'h26);
    localparam logic [N_BIT-1:0] OP_NOR = N_BIT'(8'h27);
    localparam logic [N_BIT-1:0] OP_SRL = N_BIT'(8'h02);
    localparam logic [N_BIT-1:0] OP_SRA = N_BIT'(8'h03);

    typedef enum logic [2:0] {
        RX_A,
        RX_B,
        RX_OP,
        EXEC,
        TX
    } state_t;

    state_t             state, state_next;
    logic [N_BIT-1:0]   a, b, op, res, alu_res;
    logic [CNT_W-1:0]   idle_cnt;
    logic               pop, push, timeout_hit;

    // ALU; shifts by >= N_BIT naturally give 0 (SRL) or all sign bits (SRA)
    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD:  alu_res = a + b;
            OP_SUB:  alu_res = a - b;
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_NOR:  alu_res = ~(a | b);
            OP_SRL:  alu_res = a >> b;
            OP_SRA:  alu_res = N_BIT'($signed(a) >>> b);
            default: alu_res = '0;
        endcase
    end

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) state <= RX_A;
        else       state <= state_next;
    end

    // Next-state and strobe decode; a pending byte beats the idle timeout
    always_comb begin
        state_next  = state;
        pop         = 1'b0;
        push        = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            RX_A: begin
                pop = ~rx_empty;
                if (pop) state_next = RX_B;
            end
            RX_B: begin
                pop = ~rx_empty;
                if (pop) begin
                    state_next = RX_OP;
                end else if (idle_cnt == IDLE_LAST) begin
                    state_next  = RX_A;
                    timeout_hit = 1'b1;
                end
            end
            RX_OP: begin
                pop = ~rx_empty;
                if (pop) begin
                    state_next = EXEC;
                end else if (idle_cnt == IDLE_LAST) begin
                    state_next  = RX_A;
                    timeout_hit = 1'b1;
                end
            end
            EXEC: state_next = TX;
            TX: begin
                push = ~tx_full;
                if (push) state_next = RX_A;
            end
            default: state_next = RX_A;
        endcase
    end

    // Combinational outputs are forced low while RESET is asserted
    assign rd_uart = pop & ~RESET;
    assign wr_uart = push & ~RESET;
    assign busy    = (state != RX_A) & ~RESET;
    assign w_data  = RESET ? '0 : res;

    // Operand capture, result, idle counter and timeout pulse
    always_ff @(posedge CLK) begin
        if (RESET) begin
            a           <= '0;
            b           <= '0;
            op          <= '0;
            res         <= '0;
            leds        <= '0;
            idle_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= timeout_hit;
            if (pop) begin
                case (state)
                    RX_A:    a  <= r_data;
                    RX_B:    b  <= r_data;
                    RX_OP:   op <= r_data;
                    default: ;
                endcase
            end
            if (state == EXEC) begin
                res  <= alu_res;
                leds <= alu_res;
            end
            if (pop || timeout_hit) begin
                idle_cnt <= '0;
            end else if ((state == RX_B || state == RX_OP) && rx_empty) begin
                idle_cnt <= idle_cnt + CNT_W'(1);
            end
        end
    end

endmodule
